// File: rtl/wb_commit_unit_pkg.sv
// Shared core definitions for the writeback commit stage:
// load funct3 codes, datapath width and the commit entry bundle.
package wb_commit_unit_pkg;

  localparam int CORE_XLEN = 64;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_LDU = 3'b111
  } load_f3_e;

  typedef struct packed {
    logic                 reg_write;
    logic [4:0]           rd;
    logic [CORE_XLEN-1:0] data;
  } commit_t;

endpackage

// File: rtl/wb_commit_unit_if.sv
// MEM -> WB result handshake bundle (valid/ready).
// master = MEM stage, slave = commit unit.
interface wb_commit_unit_if;
  import wb_commit_unit_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_reg_write;
  logic                 in_mem_to_reg;
  logic [4:0]           in_rd;
  logic [CORE_XLEN-1:0] in_alu_result;
  logic [CORE_XLEN-1:0] in_load_data;
  logic [2:0]           in_funct3;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg,
    output in_rd, in_alu_result, in_load_data,
    output in_funct3,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg,
    input  in_rd, in_alu_result, in_load_data,
    input  in_funct3,
    output in_ready
  );

endinterface

// File: rtl/wb_commit_unit_load_extend.sv
// Writeback value select: ALU result or aligned,
// shifted and sign/zero-extended load data.
module wb_load_extend
  import wb_commit_unit_pkg::*;
(
  input  logic                 mem_to_reg,
  input  logic [CORE_XLEN-1:0] alu_result,
  input  logic [CORE_XLEN-1:0] load_data,
  input  logic [2:0]           funct3,
  output logic [CORE_XLEN-1:0] value
);

  logic [CORE_XLEN-1:0] sh;
  logic [CORE_XLEN-1:0] ext;

  assign sh = load_data >> {alu_result[2:0], 3'b000};

  always_comb begin
    ext = sh;
    unique case (funct3)
      F3_LB:  ext = {{(CORE_XLEN-8){sh[7]}}, sh[7:0]};
      F3_LH:  ext = {{(CORE_XLEN-16){sh[15]}}, sh[15:0]};
      F3_LW:  ext = {{(CORE_XLEN-32){sh[31]}}, sh[31:0]};
      F3_LD:  ext = sh;
      F3_LBU: ext = {{(CORE_XLEN-8){1'b0}}, sh[7:0]};
      F3_LHU: ext = {{(CORE_XLEN-16){1'b0}}, sh[15:0]};
      F3_LWU: ext = {{(CORE_XLEN-32){1'b0}}, sh[31:0]};
      F3_LDU: ext = sh;
      default: ext = sh;
    endcase
  end

  assign value = mem_to_reg ? ext : alu_result;

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit: in-order queue feeding a registered regfile write port.
// Optional WB_INSTRET_EN adds the retire_count counter.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = CORE_XLEN
) (
  input  logic             clk,
  input  logic             reset,
  wb_commit_unit_if.slave  mem,
  input  logic             hold,
  output logic             RegWrite,
  output logic [4:0]       RD,
  output logic [XLEN-1:0]  WriteData
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]      retire_count
`endif
);

  localparam int PW = $clog2(DEPTH);

  commit_t              q [DEPTH];
  logic [PW-1:0]        wp, rp;
  logic [PW:0]          count;
  logic [CORE_XLEN-1:0] ext;
  commit_t              in_e, head;
  logic                 push, pop, bypass, q_wr, q_rd, empty;

  wb_load_extend u_ext (
    .mem_to_reg (mem.in_mem_to_reg),
    .alu_result (mem.in_alu_result),
    .load_data  (mem.in_load_data),
    .funct3     (mem.in_funct3),
    .value      (ext)
  );

  assign mem.in_ready = (count < (PW+1)'(DEPTH)) && !reset;

  assign in_e.reg_write = mem.in_reg_write;
  assign in_e.rd        = mem.in_rd;
  assign in_e.data      = ext;

  assign empty  = (count == '0);
  assign push   = mem.in_valid && mem.in_ready;
  assign pop    = !hold && (!empty || push);
  // empty queue: the incoming result goes straight to the output register
  assign bypass = pop && empty;
  assign q_wr   = push && !bypass;
  assign q_rd   = pop && !empty;
  assign head   = empty ? in_e : q[rp];

  always_ff @(posedge clk) begin
    if (q_wr) q[wp] <= in_e;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (q_wr) wp <= wp + PW'(1);
      if (q_rd) rp <= rp + PW'(1);
      count <= count + (PW+1)'(q_wr) - (PW+1)'(q_rd);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else if (pop) begin
      RegWrite  <= head.reg_write && (head.rd != 5'd0);
      RD        <= head.rd;
      WriteData <= head.data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    retire_count <= '0;
    else if (pop) retire_count <= retire_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: directed vectors,
// expected commits queued at issue, checked by a commit monitor.
module tb_wb_commit_unit;
  import wb_commit_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
`ifdef WB_INSTRET_EN
  logic [63:0] retire_count;
  logic [63:0] rc0;
`endif

  wb_commit_unit_if bus();

  wb_commit_unit #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (bus),
    .hold      (hold),
    .RegWrite  (RegWrite),
    .RD        (RD),
    .WriteData (WriteData)
`ifdef WB_INSTRET_EN
    ,
    .retire_count (retire_count)
`endif
  );

  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  commit_t expq[$];
  commit_t mon_e;
  int      run = 0;
  int      max_run = 0;
  int      accepts;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // commit monitor: every regfile write must match the oldest expected one
  always @(negedge clk) begin
    if (!reset) begin
      if (RegWrite) begin
        run++;
        if (run > max_run) max_run = run;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious write: got rd=%0d data=%h expected none",
                   RD, WriteData);
        end else begin
          mon_e = expq.pop_front();
          check("commit rd", 64'(RD), 64'(mon_e.rd));
          check("commit data", WriteData, mon_e.data);
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic send(input logic we, input logic m2r, input logic [4:0] rd,
                      input logic [63:0] alu, input logic [63:0] ld,
                      input logic [2:0] f3, input logic [63:0] expv);
    int tmo = 0;
    @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.in_reg_write  = we;
    bus.in_mem_to_reg = m2r;
    bus.in_rd         = rd;
    bus.in_alu_result = alu;
    bus.in_load_data  = ld;
    bus.in_funct3     = f3;
    while (!bus.in_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send timeout rd=%0d: got in_ready=0 expected 1", rd);
      bus.in_valid = 1'b0;
      return;
    end
    if (we && rd != 5'd0) expq.push_back('{1'b1, rd, expv});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.in_mem_to_reg = 1'b0;
    bus.in_rd         = '0;
    bus.in_alu_result = '0;
    bus.in_load_data  = '0;
    bus.in_funct3     = '0;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset RegWrite", 64'(RegWrite), 64'd0);
    check("reset RD", 64'(RD), 64'd0);
    check("reset WriteData", WriteData, 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
`ifdef WB_INSTRET_EN
    check("reset retire_count", retire_count, 64'd0);
`endif
    reset = 1'b0;

    // single ALU op: one-cycle write pulse
    send(1, 0, 5'd5, 64'h1234, 64'h0, 3'b000, 64'h1234);
    check("alu RegWrite", 64'(RegWrite), 64'd1);
    check("alu RD", 64'(RD), 64'd5);
    check("alu WriteData", WriteData, 64'h1234);
    @(posedge clk);
    #1 check("alu pulse end", 64'(RegWrite), 64'd0);

    // load extension vectors
    send(1, 1, 5'd7, 64'h1, 64'h8000, 3'b000, 64'hFFFF_FFFF_FFFF_FF80);
    send(1, 1, 5'd7, 64'h1, 64'h8000, 3'b100, 64'h80);
    send(1, 1, 5'd8, 64'h4, 64'hFEDC_BA98_7654_3210, 3'b010,
         64'hFFFF_FFFF_FEDC_BA98);
    send(1, 1, 5'd8, 64'h4, 64'hFEDC_BA98_7654_3210, 3'b110,
         64'h0000_0000_FEDC_BA98);
    send(1, 1, 5'd9, 64'h6, 64'hFEDC_BA98_7654_3210, 3'b001,
         64'hFFFF_FFFF_FFFF_FEDC);
    send(1, 1, 5'd9, 64'h2, 64'hFEDC_BA98_7654_3210, 3'b101, 64'h7654);
    send(1, 1, 5'd11, 64'h0, 64'hFEDC_BA98_7654_3210, 3'b011,
         64'hFEDC_BA98_7654_3210);
    send(1, 1, 5'd11, 64'h3, 64'hFEDC_BA98_7654_3210, 3'b111,
         64'h0000_00FE_DCBA_9876);
    send(1, 1, 5'd12, 64'h0, 64'hFEDC_BA98_7654_3210, 3'b000, 64'h10);
    repeat (3) @(negedge clk);

    // x0 write suppressed but retired
`ifdef WB_INSTRET_EN
    rc0 = retire_count;
`endif
    send(1, 0, 5'd0, 64'hDEAD, 64'h0, 3'b000, 64'hDEAD);
    check("x0 RegWrite", 64'(RegWrite), 64'd0);
`ifdef WB_INSTRET_EN
    check("x0 retire_count", retire_count, rc0 + 64'd1);
`endif
    repeat (2) @(negedge clk);

    // hold: queue fills to two, then drains in order
    hold = 1'b1;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold RegWrite", 64'(RegWrite), 64'd0);
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = 1'b1;
      bus.in_mem_to_reg = 1'b0;
      bus.in_rd         = 5'(20 + accepts);
      bus.in_alu_result = 64'h100 + 64'(accepts);
      if (bus.in_ready) begin
        expq.push_back('{1'b1, 5'(20 + accepts), 64'h100 + 64'(accepts)});
        accepts++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("hold accepts", 64'(accepts), 64'd2);
    check("hold in_ready", 64'(bus.in_ready), 64'd0);
    hold = 1'b0;
    @(negedge clk);
    check("drain1 RegWrite", 64'(RegWrite), 64'd1);
    check("drain in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("drain2 RegWrite", 64'(RegWrite), 64'd1);
    repeat (3) @(negedge clk);

    // back-to-back: ten writes with no bubbles
    max_run = 0;
    for (int i = 1; i <= 10; i++)
      send(1, 0, 5'(i), 64'h1000 + 64'(i), 64'h0, 3'b000,
           64'h1000 + 64'(i));
    repeat (3) @(negedge clk);
    check("back-to-back run", 64'(max_run), 64'd10);

    // reset with two queued entries: discarded
    @(negedge clk);
    hold = 1'b1;
    send(1, 0, 5'd30, 64'h300, 64'h0, 3'b000, 64'h300);
    send(1, 0, 5'd31, 64'h301, 64'h0, 3'b000, 64'h301);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset RegWrite", 64'(RegWrite), 64'd0);
    check("mid reset RD", 64'(RD), 64'd0);
    check("mid reset WriteData", WriteData, 64'd0);
    check("mid reset in_ready", 64'(bus.in_ready), 64'd0);
`ifdef WB_INSTRET_EN
    check("mid reset retire_count", retire_count, 64'd0);
`endif
    expq.delete();
    hold = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post reset RegWrite", 64'(RegWrite), 64'd0);
    check("post reset in_ready", 64'(bus.in_ready), 64'd1);

    check("scoreboard drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
